// File: rtl/uart_rx_8bit_frame_if.sv
// Receive-side line interface of the 8-bit UART framer: baud enable, serial
// input, line-control fields and the per-word result strobe with its flags.
interface uart_rx_8bit_frame_if;
  logic       brcx16;
  logic       srx;
  int         num_bits;
  logic       parity_en;
  logic       parity_ev;
  logic [7:0] dout;
  logic       wr;
  logic       parity_er;
  logic       frame_er;
  logic       break_itr;
  logic       busyn;

  modport master (
    output brcx16, srx, num_bits, parity_en, parity_ev,
    input  dout, wr, parity_er, frame_er, break_itr, busyn
  );

  modport slave (
    input  brcx16, srx, num_bits, parity_en, parity_ev,
    output dout, wr, parity_er, frame_er, break_itr, busyn
  );
endinterface

// File: rtl/uart_rx_8bit_frame.sv
// 8-bit UART receive framer: 16x oversampling, 5..8 data bits, optional parity,
// first-stop check, break detect. `define UART_RX_MAJORITY_EN for 3-tick majority sampling.
module uart_rx_8bit_frame (
  input logic                  clk,
  input logic                  rst,
  uart_rx_8bit_frame_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t     state;
  logic       rx_meta;
  logic       rx_s;
  logic       samp;
  logic [3:0] cnt;
  logic [2:0] bit_cnt;
  logic [3:0] bits_n;
  logic       last_bit;
  logic [7:0] shreg;
  logic       par_acc;
  logic       zero_acc;
  logic       p_err;
  logic [7:0] dout_r;
  logic       wr_r;
  logic       parity_er_r;
  logic       frame_er_r;
  logic       break_itr_r;
  logic       busyn_r;

  // srx is asynchronous to clk; resetting to 1 keeps the idle level after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.srx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Majority window = the two previous brcx16 ticks plus the current one.
  logic [1:0] rx_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_hist <= 2'b11;
    end else if (bus.brcx16) begin
      rx_hist <= {rx_hist[0], rx_s};
    end
  end

  assign samp = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
  assign samp = rx_s;
`endif

  always_comb begin
    bits_n = 4'd8;
    if (bus.num_bits >= 5 && bus.num_bits <= 8) begin
      bits_n = bus.num_bits[3:0];
    end
  end

  assign last_bit = ({1'b0, bit_cnt} == (bits_n - 4'd1));

  // NOTE: all state below uses non-blocking assignments so every branch reads
  // the pre-edge values; shreg is reset too, so dout never exposes X after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'd0;
      par_acc     <= 1'b0;
      zero_acc    <= 1'b0;
      p_err       <= 1'b0;
      dout_r      <= 8'd0;
      wr_r        <= 1'b0;
      parity_er_r <= 1'b0;
      frame_er_r  <= 1'b0;
      break_itr_r <= 1'b0;
      busyn_r     <= 1'b1;
    end else begin
      wr_r <= 1'b0;
      if (bus.brcx16) begin
        case (state)
          S_IDLE: begin
            cnt     <= 4'd0;
            bit_cnt <= 3'd0;
            if (!rx_s) begin
              state   <= S_START;
              busyn_r <= 1'b0;
            end
          end

          S_START: begin
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              if (samp) begin
                state   <= S_IDLE;
                busyn_r <= 1'b1;
              end else begin
                state    <= S_DATA;
                bit_cnt  <= 3'd0;
                shreg    <= 8'd0;
                par_acc  <= 1'b0;
                zero_acc <= 1'b1;
                p_err    <= 1'b0;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end

          S_DATA: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              shreg[bit_cnt] <= samp;
              par_acc        <= par_acc ^ samp;
              zero_acc       <= zero_acc & ~samp;
              bit_cnt        <= bit_cnt + 3'd1;
              if (last_bit) begin
                state <= bus.parity_en ? S_PARITY : S_STOP;
              end
            end
          end

          S_PARITY: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              // Zero when data plus parity bit has the configured parity.
              p_err    <= par_acc ^ samp ^ ~bus.parity_ev;
              zero_acc <= zero_acc & ~samp;
              state    <= S_STOP;
            end
          end

          S_STOP: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              wr_r        <= 1'b1;
              dout_r      <= shreg;
              frame_er_r  <= ~samp;
              parity_er_r <= p_err & bus.parity_en;
              break_itr_r <= zero_acc & ~samp;
              if (samp) begin
                state   <= S_IDLE;
                busyn_r <= 1'b1;
              end else begin
                state <= S_BRK_WAIT;
              end
            end
          end

          S_BRK_WAIT: begin
            // A held-low line must return high before another start is accepted.
            if (rx_s) begin
              state   <= S_IDLE;
              busyn_r <= 1'b1;
              cnt     <= 4'd0;
            end
          end

          default: begin
            state   <= S_IDLE;
            busyn_r <= 1'b1;
            cnt     <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.dout      = dout_r;
  assign bus.wr        = wr_r;
  assign bus.parity_er = parity_er_r;
  assign bus.frame_er  = frame_er_r;
  assign bus.break_itr = break_itr_r;
  assign bus.busyn     = busyn_r;

endmodule

// File: tb/tb_uart_rx_8bit_frame.sv
// Self-checking bench for uart_rx_8bit_frame: frame-level expected-word model
// with a per-cycle output compare, plus literal spot checks after each scenario.
module tb_uart_rx_8bit_frame;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  logic clk;
  logic rst;
  int   div;
  int   div_cnt;
  int   checks;
  int   failures;
  int   wr_count;
  exp_t exp_q[$];
  exp_t held;

  uart_rx_8bit_frame_if intf ();

  uart_rx_8bit_frame dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud enable: one clk-wide pulse every div clocks, changed on the falling edge.
  initial begin
    div_cnt = 0;
    intf.brcx16 = 1'b0;
    forever begin
      @(negedge clk);
      if (div_cnt >= div - 1) begin
        intf.brcx16 = 1'b1;
        div_cnt = 0;
      end else begin
        intf.brcx16 = 1'b0;
        div_cnt++;
      end
    end
  end

  // Per-cycle compare: each wr consumes one expected word; flags hold between strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (intf.wr === 1'b1) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'd1, 32'd0);
        end else begin
          held = exp_q.pop_front();
        end
      end
      check("dout", {24'd0, intf.dout}, {24'd0, held.d});
      check("parity_er", {31'd0, intf.parity_er}, {31'd0, held.pe});
      check("frame_er", {31'd0, intf.frame_er}, {31'd0, held.fe});
      check("break_itr", {31'd0, intf.break_itr}, {31'd0, held.bi});
    end
  end

  function automatic exp_t model_frame(input logic [7:0] data, input int nb, input logic pen,
                                       input logic pev, input logic pbit, input logic stopb);
    exp_t e;
    int   n;
    int   ones;
    n    = (nb >= 5 && nb <= 8) ? nb : 8;
    ones = 0;
    e.d  = 8'd0;
    for (int i = 0; i < n; i++) begin
      e.d[i] = data[i];
      ones += int'(data[i]);
    end
    if (pen) ones += int'(pbit);
    e.pe = pen && ((ones % 2) != (pev ? 0 : 1));
    e.fe = !stopb;
    e.bi = (e.d == 8'd0) && (!pen || !pbit) && !stopb;
    return e;
  endfunction

  task automatic drive_bit(input logic v);
    intf.srx = v;
    repeat (16 * div) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic stopb);
    int n;
    n = (intf.num_bits >= 5 && intf.num_bits <= 8) ? intf.num_bits : 8;
    exp_q.push_back(model_frame(data, intf.num_bits, intf.parity_en, intf.parity_ev, pbit, stopb));
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(data[i]);
    if (intf.parity_en) drive_bit(pbit);
    drive_bit(stopb);
  endtask

  task automatic settle();
    int k;
    idle_bits(2);
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
    check("busyn_idle", {31'd0, intf.busyn}, 32'd1);
  endtask

  task automatic set_cfg(input int nb, input logic pen, input logic pev);
    intf.num_bits  = nb;
    intf.parity_en = pen;
    intf.parity_ev = pev;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    checks   = 0;
    failures = 0;
    wr_count = 0;
    held     = '{d: 8'd0, pe: 1'b0, fe: 1'b0, bi: 1'b0};
    div      = 1;
    rst      = 1'b1;
    intf.srx = 1'b1;
    set_cfg(8, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("rst_dout", {24'd0, intf.dout}, 32'd0);
    check("rst_wr", {31'd0, intf.wr}, 32'd0);
    check("rst_flags", {29'd0, intf.parity_er, intf.frame_er, intf.break_itr}, 32'd0);
    check("rst_busyn", {31'd0, intf.busyn}, 32'd1);
    #1 rst = 1'b0;
    idle_bits(1);

    // 8N1 0xA5 at 160 clks per bit.
    div = 10;
    idle_bits(1);
    w0 = wr_count;
    send_frame(8'hA5, 1'b0, 1'b1);
    settle();
    check("a5_wr_count", wr_count - w0, 32'd1);
    check("a5_dout", {24'd0, intf.dout}, 32'hA5);
    check("a5_flags", {29'd0, intf.parity_er, intf.frame_er, intf.break_itr}, 32'd0);
    div = 1;
    idle_bits(1);

    // 5 data bits, even parity.
    set_cfg(5, 1'b1, 1'b1);
    send_frame(8'h13, 1'b1, 1'b1);
    settle();
    check("p5_good_dout", {24'd0, intf.dout}, 32'h13);
    check("p5_good_pe", {31'd0, intf.parity_er}, 32'd0);
    send_frame(8'h13, 1'b0, 1'b1);
    settle();
    check("p5_bad_pe", {31'd0, intf.parity_er}, 32'd1);

    // Start-bit glitch of 4 ticks.
    w0 = wr_count;
    intf.srx = 1'b0;
    repeat (4) @(negedge clk);
    intf.srx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", {31'd0, intf.busyn}, 32'd0);
    settle();
    check("glitch_no_wr", wr_count - w0, 32'd0);
    check("glitch_dout", {24'd0, intf.dout}, 32'h13);

    // Stop bit low with non-zero data.
    set_cfg(8, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    settle();
    check("fe_dout", {24'd0, intf.dout}, 32'h5A);
    check("fe_flag", {31'd0, intf.frame_er}, 32'd1);
    check("fe_break", {31'd0, intf.break_itr}, 32'd0);

    // Break: line low for three frame times.
    w0 = wr_count;
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, bi: 1'b1});
    for (int i = 0; i < 30; i++) drive_bit(1'b0);
    check("brk_wait_busy", {31'd0, intf.busyn}, 32'd0);
    check("brk_wr_count", wr_count - w0, 32'd1);
    check("brk_flag", {31'd0, intf.break_itr}, 32'd1);
    idle_bits(2);
    send_frame(8'h3C, 1'b0, 1'b1);
    settle();
    check("post_brk_dout", {24'd0, intf.dout}, 32'h3C);
    check("post_brk_flags", {29'd0, intf.parity_er, intf.frame_er, intf.break_itr}, 32'd0);

    // Back-to-back frames, odd parity 7-bit, and out-of-range width.
    send_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1);
    settle();
    check("b2b_dout", {24'd0, intf.dout}, 32'h42);
    set_cfg(7, 1'b1, 1'b0);
    send_frame(8'hD5, 1'b1, 1'b1);
    settle();
    check("o7_dout", {24'd0, intf.dout}, 32'h55);
    check("o7_pe", {31'd0, intf.parity_er}, 32'd0);
    set_cfg(12, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    settle();
    check("nb12_dout", {24'd0, intf.dout}, 32'hC3);

    // Reset in the middle of data bit 3.
    set_cfg(8, 1'b0, 1'b0);
    w0 = wr_count;
    intf.srx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      intf.srx = (8'h7E >> i) & 8'h01;
      repeat (16) @(negedge clk);
    end
    intf.srx = 1'b1;
    repeat (8) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    held = '{d: 8'd0, pe: 1'b0, fe: 1'b0, bi: 1'b0};
    repeat (3) @(negedge clk);
    check("mid_rst_dout", {24'd0, intf.dout}, 32'd0);
    check("mid_rst_busyn", {31'd0, intf.busyn}, 32'd1);
    #1 rst = 1'b0;
    idle_bits(2);
    check("mid_rst_no_wr", wr_count - w0, 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1);
    settle();
    check("after_rst_dout", {24'd0, intf.dout}, 32'h7E);
    check("after_rst_wr_count", wr_count - w0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
